// File: rtl/scytale_pkg.sv
// Shared constants, state encoding and sizing helpers for the scytale cipher blocks.
package scytale_pkg;

    localparam int DEF_D_WIDTH       = 8;
    localparam int DEF_KEY_WIDTH     = 8;
    localparam int DEF_MAX_NOF_CHARS = 50;

    localparam logic [7:0] START_ENCRYPTION_TOKEN = 8'hFA;
    localparam logic [7:0] START_DECRYPTION_TOKEN = 8'hFA;

    localparam int ADDR_W = $clog2(DEF_MAX_NOF_CHARS);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Address width that stays at least one bit for degenerate depths.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/scytale_char_buffer.sv
// Character store: one synchronous write port, one combinational read port with
// an in-range flag so wide read pointers never index past the last entry.
module scytale_char_buffer
    import scytale_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int DEPTH   = DEF_MAX_NOF_CHARS,
    parameter int PTR_W   = 2 * DEF_KEY_WIDTH,
    parameter int AW      = addr_width(DEF_MAX_NOF_CHARS)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [D_WIDTH-1:0] wr_data_i,
    input  logic [PTR_W-1:0]   rd_addr_i,
    output logic [D_WIDTH-1:0] rd_data_o,
    output logic               rd_in_range_o
);

    logic [D_WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents deliberately survive reset and message boundaries.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Guarded read so an out-of-range pointer returns zero instead of aliasing.
    always_comb begin
        rd_in_range_o = (rd_addr_i < PTR_W'(DEPTH));
        if (rd_in_range_o) begin
            rd_data_o = mem_q[rd_addr_i[AW-1:0]];
        end else begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/scytale_encryption.sv
// Scytale transposition encryptor: buffers plaintext until the start token, then
// streams the buffer column-wise over a kn x km grid, padding past the loaded length.
module scytale_encryption #(
    parameter int                   D_WIDTH                = scytale_pkg::DEF_D_WIDTH,
    parameter int                   KEY_WIDTH              = scytale_pkg::DEF_KEY_WIDTH,
    parameter int                   MAX_NOF_CHARS          = scytale_pkg::DEF_MAX_NOF_CHARS,
    parameter logic [D_WIDTH-1:0]   START_ENCRYPTION_TOKEN = scytale_pkg::START_ENCRYPTION_TOKEN,
    parameter logic [D_WIDTH-1:0]   PAD_CHAR               = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);
    import scytale_pkg::*;

    localparam int AW = addr_width(MAX_NOF_CHARS);
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int PW = 2 * KEY_WIDTH;

    state_t               state_q;
    logic [CW-1:0]        count_q;
    logic [KEY_WIDTH-1:0] kn_q, km_q, k_q, j_q;
    logic [PW-1:0]        ptr_q;
    logic [D_WIDTH-1:0]   data_q;
    logic                 valid_q;
    logic                 busy_q;

    logic                 wr_en_d;
    logic                 is_token_d;
    logic [PW-1:0]        grid_len_d;
    logic [D_WIDTH-1:0]   emit_char_d;
    logic [D_WIDTH-1:0]   rd_data_s;
    logic                 rd_in_range_s;

    scytale_char_buffer #(
        .D_WIDTH (D_WIDTH),
        .DEPTH   (MAX_NOF_CHARS),
        .PTR_W   (PW),
        .AW      (AW)
    ) u_buf (
        .clk           (clk),
        .we_i          (wr_en_d),
        .wr_addr_i     (count_q[AW-1:0]),
        .wr_data_i     (data_i),
        .rd_addr_i     (ptr_q),
        .rd_data_o     (rd_data_s),
        .rd_in_range_o (rd_in_range_s)
    );

    // Load-side decode and the character selected for the current grid slot.
    always_comb begin
        is_token_d = (data_i == START_ENCRYPTION_TOKEN);
        wr_en_d    = (state_q == LOAD) && valid_i && !is_token_d
                     && (count_q < CW'(MAX_NOF_CHARS));
        grid_len_d = PW'(key_N) * PW'(key_M);
        if ((ptr_q < PW'(count_q)) && rd_in_range_s) begin
            emit_char_d = rd_data_s;
        end else begin
            emit_char_d = PAD_CHAR;
        end
    end

    // Control FSM with registered outputs; ptr walks down a column in steps of km.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            count_q <= '0;
            kn_q    <= '0;
            km_q    <= '0;
            k_q     <= '0;
            j_q     <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    if (valid_i && is_token_d) begin
                        kn_q    <= key_N;
                        km_q    <= key_M;
                        k_q     <= '0;
                        j_q     <= '0;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (grid_len_d == '0) ? DONE : EMIT;
                    end else if (wr_en_d) begin
                        count_q <= count_q + CW'(1);
                    end
                end
                EMIT: begin
                    data_q  <= emit_char_d;
                    valid_q <= 1'b1;
                    if (j_q == kn_q - KEY_WIDTH'(1)) begin
                        j_q   <= '0;
                        k_q   <= k_q + KEY_WIDTH'(1);
                        ptr_q <= PW'(k_q) + PW'(1);
                        if (k_q == km_q - KEY_WIDTH'(1)) begin
                            state_q <= DONE;
                        end
                    end else begin
                        j_q   <= j_q + KEY_WIDTH'(1);
                        ptr_q <= ptr_q + PW'(km_q);
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                    state_q <= LOAD;
                end
                default: begin
                    state_q <= LOAD;
                    count_q <= '0;
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign busy    = busy_q;

endmodule

// File: doc/scytale_encryption.md
# scytale_encryption

Scytale transposition encryptor, the transmit-side counterpart of the scytale decryptor. It buffers a plaintext stream of `D_WIDTH` characters until a start token arrives. It then emits the ciphertext one character per cycle by reading the buffer column-wise for a `key_N` × `key_M` grid. The output stream is exactly what the decryptor consumes: `C[k*key_N + j] = P[j*key_M + k]`.

## Interface
- `D_WIDTH`, 8, character width.
- `KEY_WIDTH`, 8, width of each key.
- `MAX_NOF_CHARS`, 50, buffer depth in characters.
- `START_ENCRYPTION_TOKEN`, 8'hFA, character that ends loading and starts emission.
- `PAD_CHAR`, 8'h00, character emitted for grid positions beyond the loaded length.
- `clk`, input, 1, sole clock; all logic on its rising edge.
- `rst`, input, 1, synchronous, active-high reset.
- `data_i`, input, `D_WIDTH`, plaintext character or token.
- `valid_i`, input, 1, `data_i` qualifier.
- `key_N`, input, `KEY_WIDTH`, number of grid rows (plaintext row length is `key_M`).
- `key_M`, input, `KEY_WIDTH`, number of grid columns.
- `data_o`, output, `D_WIDTH`, ciphertext character, registered.
- `valid_o`, output, 1, `data_o` qualifier, registered.
- `busy`, output, 1, high while encrypting; input is ignored while high.

## Operation
- States: LOAD (reset state), EMIT, DONE.
- **LOAD**
  - `valid_i=1` with non-token data and `count < MAX_NOF_CHARS`: write `buf[count]`, then `count++`.
  - When `count == MAX_NOF_CHARS`, further characters are dropped silently.
  - `valid_i=1` with data equal to the token: latch `key_N` and `key_M` into `kn`/`km`, clear `k`/`j`, set `ptr=0`, `busy<=1`, go to EMIT.
  - If `kn*km == 0`, go to DONE instead of EMIT.
- **EMIT**, one character per cycle:
  - `data_o <= (ptr < count) ? buf[ptr] : PAD_CHAR`, `valid_o <= 1`.
  - Inner loop over `j` in `0..kn-1`: `ptr += km`.
  - When `j == kn-1`: `j=0`, `k++`, `ptr=k+1` (next column start).
  - When `j == kn-1` and `k == km-1`: go to DONE.
  - `ptr` is compared against `count` and never used to address past `MAX_NOF_CHARS-1`. Out-of-range positions yield `PAD_CHAR`.
- **DONE**, one cycle: `valid_o<=0`, `data_o<=0`, `busy<=0`, `count<=0`, go to LOAD. Buffer contents are not cleared.
- While `busy=1`, `valid_i` is ignored entirely, including tokens.
- Keys changing during EMIT have no effect; only the latched copies are used.
- Grid length `L = kn*km` is computed at `2*KEY_WIDTH` bits. `ptr` is `2*KEY_WIDTH` bits wide, so no wrap is possible.
- Reset at any time: state LOAD, `count=0`, `data_o=0`, `valid_o=0`, `busy=0`. An emission in progress is abandoned with no further `valid_o`.

## Timing
- Token sampled at edge t0:
  - `busy` is 1 after t0.
  - `valid_o` is 1 after edges t1..tL, carrying characters 0..L-1 in order.
  - At edge tL+1, `valid_o`, `data_o` and `busy` return to 0.
- `busy` is high for L+1 cycles, or 1 cycle when `L=0`.
- The first character of the next message is accepted at edge tL+2 at the earliest.
- No backpressure: the downstream must accept every `valid_o` cycle.
- Reset values: `data_o=0`, `valid_o=0`, `busy=0`.

## Structure
- Package `scytale_pkg`:
  - Token constants `START_ENCRYPTION_TOKEN` / `START_DECRYPTION_TOKEN`.
  - Default `D_WIDTH` / `KEY_WIDTH` / `MAX_NOF_CHARS`.
  - State enum `{LOAD, EMIT, DONE}`.
  - Address width `$clog2(MAX_NOF_CHARS)`.
- Sub-module `scytale_char_buffer`: `MAX_NOF_CHARS` × `D_WIDTH` register file with one synchronous write port, one combinational read port, and an in-range flag for the read address. The FSM, column/row counters and output registers stay in the top.

## Test plan
- N=2, M=4, "ABCDEFGH"+FA → "AEBFCGDH" over 8 consecutive cycles starting one cycle after the token. `busy` high for 9 cycles. Output fed to the decryptor returns "ABCDEFGH".
- N=3, M=2, "ABCDEF"+FA → "ACEBDF". Keys changed mid-emission → output unchanged.
- N=2, M=3, "ABCD"+FA → 'A','D','B',00,'C',00 (padding).
- 52 chars then FA with N=5, M=10 → first 50 chars encrypted, chars 51–52 dropped. A token or characters sent while `busy` is high are ignored.
- FA with `count=0` and N=0 → `busy` high exactly 1 cycle, no `valid_o`.
- `rst` pulsed after the 3rd output of the "ABCDEFGH" case → `valid_o`, `busy` and `data_o` are 0 from the next edge. A new "WXYZ"+FA with N=2, M=2 → "WYXZ".
